// File: rtl/tc_down_counter_pkg.sv
// Shared types and constants for the tc_down_counter timer.
//   state_t       : FSM encoding (idle, counting, expired/done)
//   RST_VALUE     : reset value for the count and reload registers (all zero)
package tc_down_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [63:0] RST_VALUE = '0;

endpackage

// File: rtl/tc_sat_sub.sv
// Combinational saturating subtract of a fixed step; never wraps below zero.
//   value : current count (W bits)
//   diff  : value - STEP, or 0 when value <= STEP
//   zero  : diff == 0
module tc_sat_sub #(
  parameter int unsigned W    = 8,
  parameter int unsigned STEP = 1
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] diff,
  output logic         zero
);

  localparam logic [W-1:0] STEP_W = W'(STEP);

  assign diff = (value <= STEP_W) ? '0 : (value - STEP_W);
  assign zero = (diff == '0);

endmodule

// File: rtl/tc_down_counter.sv
// Loadable down-counter / timer with a sticky expiry event under a valid/ack
// handshake. Optional periodic reload when TC_DOWN_COUNTER_RELOAD_EN is defined.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   load    : capture in as the new count (and reload value)
//   in      : load value
//   start   : begin/resume counting
//   pause   : hold the count while in RUN
//   ack     : consumer acknowledges expired
//   out     : current count (registered)
//   busy    : high while in RUN (registered)
//   expired : expiry event pending, sticky until ack (registered)
//   overrun : sticky, expiry while expired still pending (reload build only)
module tc_down_counter
  import tc_down_counter_pkg::*;
#(
  parameter int          UUID      = 0,
  parameter string       NAME      = "",
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned COUNT     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] in,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 ack,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 busy,
  output logic                 expired,
  output logic                 overrun
);

  // Elaboration-time parameter sanity check.
  if (BIT_WIDTH < 1 || COUNT < 1 ||
      (BIT_WIDTH < 32 && (COUNT >> BIT_WIDTH) != 0)) begin : g_bad_param
    $error("tc_down_counter: illegal BIT_WIDTH/COUNT");
  end

  state_t               state;
  state_t               state_nx;
  logic [BIT_WIDTH-1:0] out_nx;
  logic                 busy_nx;
  logic                 expired_nx;
  logic [BIT_WIDTH-1:0] diff;
  logic                 diff_zero;
  logic                 count_step;
  logic                 zero_start;
  logic                 run_expire;
  logic                 reload_hit;
  logic                 expiry;

  tc_sat_sub #(
    .W    (BIT_WIDTH),
    .STEP (COUNT)
  ) u_sat_sub (
    .value (out),
    .diff  (diff),
    .zero  (diff_zero)
  );

  // Cycle decode; load overrides everything, start overrides pause.
  assign count_step = !load && (state == ST_RUN) && (start || !pause);
  assign zero_start = !load && (state == ST_IDLE) && start && (out == '0);
  assign run_expire = count_step && diff_zero;
  assign expiry     = zero_start || run_expire;

`ifdef TC_DOWN_COUNTER_RELOAD_EN
  logic [BIT_WIDTH-1:0] reload;
  logic [BIT_WIDTH-1:0] reload_nx;
  logic                 overrun_nx;

  // A zero reload value falls back to a one-shot exit.
  assign reload_hit = run_expire && (reload != '0);
`else
  assign reload_hit = 1'b0;
  assign overrun    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    if (load) begin
      if (start) state_nx = ST_RUN;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_nx = (out != '0) ? ST_RUN : ST_DONE;
        end
        ST_RUN: begin
          if (run_expire && !reload_hit) state_nx = ST_DONE;
        end
        ST_DONE: begin
          // A load while done can leave a nonzero count to restart from.
          if (start && (out != '0)) state_nx = ST_RUN;
          else if (ack)             state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    out_nx     = out;
    expired_nx = expired && !ack;
    busy_nx    = (state_nx == ST_RUN);

    if (load) begin
      out_nx = in;
    end else if (count_step) begin
`ifdef TC_DOWN_COUNTER_RELOAD_EN
      out_nx = reload_hit ? reload : diff;
`else
      out_nx = diff;
`endif
    end

    // A new expiry wins over an ack in the same cycle.
    if (expiry) expired_nx = 1'b1;
  end

`ifdef TC_DOWN_COUNTER_RELOAD_EN
  // Reload capture and overrun detection.
  always_comb begin
    reload_nx  = load ? in : reload;
    overrun_nx = overrun || (expiry && expired && !ack);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload  <= BIT_WIDTH'(RST_VALUE);
      overrun <= 1'b0;
    end else begin
      reload  <= reload_nx;
      overrun <= overrun_nx;
    end
  end
`endif

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out     <= BIT_WIDTH'(RST_VALUE);
      busy    <= 1'b0;
      expired <= 1'b0;
    end else begin
      out     <= out_nx;
      busy    <= busy_nx;
      expired <= expired_nx;
    end
  end

endmodule

// File: tb/tb_tc_down_counter.sv
// Randomized scoreboard bench for tc_down_counter: two instances (COUNT=1 and
// COUNT=4) share stimulus; a behavioural model pushes expected outputs per cycle.
module tb_tc_down_counter;

`ifdef TC_DOWN_COUNTER_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       ack = 1'b0;

  logic [7:0] out1, out4;
  logic       busy1, busy4, expired1, expired4, overrun1, overrun4;

  int vectors = 0;
  int miscompares = 0;

  logic [10:0] q0[$];
  logic [10:0] q1[$];

  int m_st[2];
  int m_out[2];
  int m_rel[2];
  bit m_exp[2];
  bit m_ovr[2];
  int step_of[2] = '{1, 4};

  always #5 clk = ~clk;

  tc_down_counter #(.UUID(1), .NAME("dc1"), .BIT_WIDTH(8), .COUNT(1)) u_dut1 (
    .clk(clk), .rst(rst), .load(load), .in(din), .start(start), .pause(pause),
    .ack(ack), .out(out1), .busy(busy1), .expired(expired1), .overrun(overrun1)
  );

  tc_down_counter #(.UUID(4), .NAME("dc4"), .BIT_WIDTH(8), .COUNT(4)) u_dut4 (
    .clk(clk), .rst(rst), .load(load), .in(din), .start(start), .pause(pause),
    .ack(ack), .out(out4), .busy(busy4), .expired(expired4), .overrun(overrun4)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_IDLE; m_out[k] = 0; m_rel[k] = 0; m_exp[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  // Behavioural next-cycle model for one instance.
  task automatic model_step(input int k, input bit l, input int d, input bit s,
                            input bit p, input bit a);
    int nst, nout, nrel;
    bit nexp, novr, ev;
    logic [10:0] e;
    nst = m_st[k]; nout = m_out[k]; nrel = m_rel[k];
    nexp = m_exp[k] && !a; novr = m_ovr[k]; ev = 1'b0;
    if (l) begin
      nout = d; nrel = d;
      if (s) nst = M_RUN;
    end else if (m_st[k] == M_IDLE) begin
      if (s && m_out[k] != 0) nst = M_RUN;
      else if (s) begin nst = M_DONE; ev = 1'b1; end
    end else if (m_st[k] == M_RUN) begin
      if (s || !p) begin
        nout = (m_out[k] <= step_of[k]) ? 0 : m_out[k] - step_of[k];
        if (nout == 0) begin
          ev = 1'b1;
          if (RELOAD && m_rel[k] != 0) nout = m_rel[k];
          else nst = M_DONE;
        end
      end
    end else begin
      if (s && m_out[k] != 0) nst = M_RUN;
      else if (a) nst = M_IDLE;
    end
    if (ev) begin
      if (RELOAD && m_exp[k] && !a) novr = 1'b1;
      nexp = 1'b1;
    end
    m_st[k] = nst; m_out[k] = nout; m_rel[k] = nrel; m_exp[k] = nexp; m_ovr[k] = novr;
    e = {8'(nout), (nst == M_RUN), nexp, novr};
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic step(input bit l, input int d, input bit s, input bit p, input bit a);
    @(negedge clk);
    load = l; din = 8'(d); start = s; pause = p; ack = a;
    for (int k = 0; k < 2; k++) model_step(k, l, d, s, p, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({out1, busy1, expired1, overrun1} !== 11'd0 ||
        {out4, busy4, expired4, overrun4} !== 11'd0) begin
      miscompares++;
      $display("FAIL %s: got c1=%h c4=%h, want 000", name,
               {out1, busy1, expired1, overrun1}, {out4, busy4, expired4, overrun4});
    end
  endtask

  // Asynchronous reset mid-cycle, away from any clock edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    load = 1'b0; start = 1'b0; pause = 1'b0; ack = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Monitor: compare each registered output against the scoreboard.
  always @(posedge clk) begin
    logic [10:0] e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      vectors++;
      if ({out1, busy1, expired1, overrun1} !== e) begin
        miscompares++;
        $display("FAIL count1 t=%0t: got out=%0d busy=%b exp=%b ovr=%b, want out=%0d busy=%b exp=%b ovr=%b",
                 $time, out1, busy1, expired1, overrun1, e[10:3], e[2], e[1], e[0]);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      vectors++;
      if ({out4, busy4, expired4, overrun4} !== e) begin
        miscompares++;
        $display("FAIL count4 t=%0t: got out=%0d busy=%b exp=%b ovr=%b, want out=%0d busy=%b exp=%b ovr=%b",
                 $time, out4, busy4, expired4, overrun4, e[10:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    int l, s, p, a, d;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("power_on_reset");
    #2;
    rst = 1'b1;

    // One-shot count 3 -> 0, then ack.
    step(1'b1, 3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Saturation with a non-multiple load.
    step(1'b1, 6, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Load beats pause while running, then pause holds.
    step(1'b1, 12, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 20, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(25);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Zero start expires without decrement.
    step(1'b1, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Periodic run never acked, then ack.
    step(1'b1, 2, 1'b1, 1'b0, 1'b0);
    idle(8);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset mid-count.
    step(1'b1, 9, 1'b1, 1'b0, 1'b0);
    idle(4);
    async_reset();
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      l = ($urandom_range(0, 99) < 8)  ? 1 : 0;
      s = ($urandom_range(0, 99) < 15) ? 1 : 0;
      p = ($urandom_range(0, 99) < 25) ? 1 : 0;
      a = ($urandom_range(0, 99) < 20) ? 1 : 0;
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 10));
      step(l[0], d, s[0], p[0], a[0]);
      if ($urandom_range(0, 599) == 0) async_reset();
    end

    @(posedge clk);
    #2;
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
